dc_sweep_sequencer: RTL
=======================

DC_SWEEP_SEQUENCER -- requirements
Module: dc_sweep_sequencer

Interface
REQ-001 Parameter DW, default 16, width of the bias codes and the ADC data.
REQ-002 Parameter CW, default 8, width of the sweep point counters.
REQ-003 Parameter SW, default 16, width of the settle-time counter.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-007 vg_start, vg_step  input  DW each  gate code origin and increment (outer loop).
REQ-008 vd_start, vd_step  input  DW each  drain code origin and increment (inner loop).
REQ-009 vg_count, vd_count  input  CW each  number of points per axis.
REQ-010 settle  input  SW  number of wait cycles after each DAC load.
REQ-011 vg_code, vd_code  output  DW each  registered bias codes driving the gate and drain DACs.
REQ-012 dac_load  output  1  one-cycle strobe whenever the codes are updated.
REQ-013 adc_req, adc_valid, adc_data  out/in/in  1/1/DW  drain-current conversion request, completion and data.
REQ-014 res_valid, res_ready, res_data, res_last  out/in/out/out  1/1/3*DW/1  result stream {vg_code,vd_code,current}; last flag.
REQ-015 busy, done  output  1 each  sweep in progress; one-cycle end-of-sweep pulse.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, SETTLE, SAMPLE, WAIT_ADC, EMIT, FINISH.
REQ-017 IDLE->LOAD on start=1; inputs latched that cycle; later changes to them ignored until the next sweep.
REQ-018 If vg_count==0 or vd_count==0, IDLE SHALL go directly to FINISH with no dac_load and no result.
REQ-019 LOAD SHALL drive vg_code=vg_start+i*vg_step and vd_code=vd_start+j*vd_step, modulo 2^DW (wrap, no saturation), and pulse dac_load for one cycle.
REQ-020 Codes SHALL be formed by running accumulators, not multipliers; j resets to 0 and vd_code to vd_start when i advances.
REQ-021 SETTLE SHALL last exactly settle cycles (0 = skip), then SAMPLE.
REQ-022 SAMPLE SHALL assert adc_req for exactly one cycle, then WAIT_ADC.
REQ-023 WAIT_ADC SHALL capture adc_data on the first cycle adc_valid=1; adc_valid outside WAIT_ADC is ignored.
REQ-024 EMIT SHALL hold res_valid=1 and res_data stable until res_valid&&res_ready; no data is dropped under backpressure.
REQ-025 res_last=1 only on the point i=vg_count-1, j=vd_count-1.
REQ-026 After the handshake: next j (LOAD) if j<vd_count-1; else next i with j=0 if i<vg_count-1; else FINISH.
REQ-027 FINISH SHALL pulse done for one cycle and return to IDLE; codes keep their last values.
REQ-028 busy=1 in every state except IDLE; start while busy is ignored.
REQ-029 Latency from start to the first dac_load SHALL be exactly 1 cycle.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, with the counters, vg_code, vd_code and res_data all zero.
REQ-031 rst_n low SHALL also force dac_load, adc_req, res_valid, res_last, busy and done to 0.
REQ-032 Reset mid-sweep SHALL abandon the sweep with no done pulse; a new start is required after release.

Configuration
REQ-033 Macro DC_SWEEP_AVG_EN, when defined: each point SHALL take 4 ADC conversions (SAMPLE/WAIT_ADC repeated 4 times).
REQ-034 With the macro, the current field is the sum of the 4 conversions, computed at DW+2 bits, shifted right by 2 and truncated to DW.
REQ-035 Without the macro, a single conversion is used and no accumulator hardware exists.

Verification
REQ-036 vg 2 pts start 0x100 step 0x80, vd 3 pts start 0 step 0x10, settle 2, ADC echoes vd_code -> 6 results in i-major order, res_last only on the 6th, one done pulse.
REQ-037 vd_start 0xFFF0, step 0x0020, 2 pts -> vd_code values 0xFFF0 then 0x0010.
REQ-038 res_ready held low 10 cycles during EMIT -> res_data stable, no dac_load, no adc_req until the handshake.
REQ-039 vg_count=0 with start -> busy for 1 cycle, done pulse, zero dac_load and zero res_valid.
REQ-040 rst_n low during WAIT_ADC of point 3 -> all outputs 0 in the same cycle, no done; a fresh sweep completes normally.
REQ-041 DC_SWEEP_AVG_EN, ADC returns 1,2,3,6 -> 4 adc_req pulses, current field 3.

Source files
------------

// File: rtl/dc_sweep_sequencer.sv
// dc_sweep_sequencer: two-axis DC bias sweep. The outer loop steps the gate
// code, the inner loop steps the drain code. Each point loads the DACs, waits
// a settle time, takes a drain-current conversion and emits {vg, vd, current}
// on a ready/valid stream.
// Optional build macro DC_SWEEP_AVG_EN: average 4 conversions per point.
module dc_sweep_sequencer #(
    parameter int DW = 16,
    parameter int CW = 8,
    parameter int SW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [DW-1:0]   vg_start,
    input  logic [DW-1:0]   vg_step,
    input  logic [DW-1:0]   vd_start,
    input  logic [DW-1:0]   vd_step,
    input  logic [CW-1:0]   vg_count,
    input  logic [CW-1:0]   vd_count,
    input  logic [SW-1:0]   settle,
    output logic [DW-1:0]   vg_code,
    output logic [DW-1:0]   vd_code,
    output logic            dac_load,
    output logic            adc_req,
    input  logic            adc_valid,
    input  logic [DW-1:0]   adc_data,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [3*DW-1:0] res_data,
    output logic            res_last,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        IDLE, LOAD, SETTLE, SAMPLE, WAIT_ADC, EMIT, FINISH
    } state_t;

    state_t state_q, state_d;

    // Sweep configuration captured at start; vg_start is only needed once.
    logic [DW-1:0]   vg_step_q, vg_step_d;
    logic [DW-1:0]   vd_start_q, vd_start_d;
    logic [DW-1:0]   vd_step_q, vd_step_d;
    logic [CW-1:0]   vg_count_q, vg_count_d;
    logic [CW-1:0]   vd_count_q, vd_count_d;
    logic [SW-1:0]   settle_q, settle_d;

    // Point indices and settle timer.
    logic [CW-1:0]   i_q, i_d;
    logic [CW-1:0]   j_q, j_d;
    logic [SW-1:0]   scnt_q, scnt_d;

    // Codes double as running accumulators: each step adds the increment.
    logic [DW-1:0]   vg_code_q, vg_code_d;
    logic [DW-1:0]   vd_code_q, vd_code_d;
    logic [3*DW-1:0] res_data_q, res_data_d;

    logic            dac_load_q, dac_load_d;
    logic            adc_req_q, adc_req_d;
    logic            res_valid_q, res_valid_d;
    logic            res_last_q, res_last_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [DW-1:0]   cur_d;
    logic            i_last, j_last;

`ifdef DC_SWEEP_AVG_EN
    logic [1:0]      avg_cnt_q, avg_cnt_d;
    logic [DW+1:0]   avg_acc_q, avg_acc_d;
    logic [DW+1:0]   avg_sum;
    assign avg_sum = avg_acc_q + {2'b00, adc_data};
`endif

    assign i_last = (i_q == vg_count_q - CW'(1));
    assign j_last = (j_q == vd_count_q - CW'(1));

    // Next-state and datapath decode; outputs are registered from the next state.
    always_comb begin
        state_d     = state_q;
        vg_step_d   = vg_step_q;
        vd_start_d  = vd_start_q;
        vd_step_d   = vd_step_q;
        vg_count_d  = vg_count_q;
        vd_count_d  = vd_count_q;
        settle_d    = settle_q;
        i_d         = i_q;
        j_d         = j_q;
        scnt_d      = scnt_q;
        vg_code_d   = vg_code_q;
        vd_code_d   = vd_code_q;
        res_data_d  = res_data_q;
        cur_d       = adc_data;
`ifdef DC_SWEEP_AVG_EN
        avg_cnt_d   = avg_cnt_q;
        avg_acc_d   = avg_acc_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    vg_step_d  = vg_step;
                    vd_start_d = vd_start;
                    vd_step_d  = vd_step;
                    vg_count_d = vg_count;
                    vd_count_d = vd_count;
                    settle_d   = settle;
                    if (vg_count == '0 || vd_count == '0) begin
                        // Empty sweep: no DAC activity, just the done pulse.
                        state_d = FINISH;
                    end else begin
                        i_d       = '0;
                        j_d       = '0;
                        vg_code_d = vg_start;
                        vd_code_d = vd_start;
                        state_d   = LOAD;
                    end
                end
            end
            LOAD: begin
`ifdef DC_SWEEP_AVG_EN
                avg_cnt_d = '0;
                avg_acc_d = '0;
`endif
                if (settle_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    scnt_d  = settle_q - SW'(1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (scnt_q == '0) state_d = SAMPLE;
                else              scnt_d  = scnt_q - SW'(1);
            end
            SAMPLE: begin
                state_d = WAIT_ADC;
            end
            WAIT_ADC: begin
                if (adc_valid) begin
`ifdef DC_SWEEP_AVG_EN
                    if (avg_cnt_q == 2'd3) begin
                        cur_d      = avg_sum[DW+1:2];
                        res_data_d = {vg_code_q, vd_code_q, cur_d};
                        state_d    = EMIT;
                    end else begin
                        avg_acc_d = avg_sum;
                        avg_cnt_d = avg_cnt_q + 2'd1;
                        state_d   = SAMPLE;
                    end
`else
                    res_data_d = {vg_code_q, vd_code_q, cur_d};
                    state_d    = EMIT;
`endif
                end
            end
            EMIT: begin
                // res_valid is high throughout EMIT, so ready alone completes it.
                if (res_ready) begin
                    if (!j_last) begin
                        j_d       = j_q + CW'(1);
                        vd_code_d = vd_code_q + vd_step_q;
                        state_d   = LOAD;
                    end else if (!i_last) begin
                        i_d       = i_q + CW'(1);
                        j_d       = '0;
                        vg_code_d = vg_code_q + vg_step_q;
                        vd_code_d = vd_start_q;
                        state_d   = LOAD;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        dac_load_d  = (state_d == LOAD);
        adc_req_d   = (state_d == SAMPLE);
        res_valid_d = (state_d == EMIT);
        res_last_d  = (state_d == EMIT) && i_last && j_last;
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == FINISH);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath and registered outputs; reset abandons any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vg_step_q   <= '0;
            vd_start_q  <= '0;
            vd_step_q   <= '0;
            vg_count_q  <= '0;
            vd_count_q  <= '0;
            settle_q    <= '0;
            i_q         <= '0;
            j_q         <= '0;
            scnt_q      <= '0;
            vg_code_q   <= '0;
            vd_code_q   <= '0;
            res_data_q  <= '0;
            dac_load_q  <= 1'b0;
            adc_req_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            vg_step_q   <= vg_step_d;
            vd_start_q  <= vd_start_d;
            vd_step_q   <= vd_step_d;
            vg_count_q  <= vg_count_d;
            vd_count_q  <= vd_count_d;
            settle_q    <= settle_d;
            i_q         <= i_d;
            j_q         <= j_d;
            scnt_q      <= scnt_d;
            vg_code_q   <= vg_code_d;
            vd_code_q   <= vd_code_d;
            res_data_q  <= res_data_d;
            dac_load_q  <= dac_load_d;
            adc_req_q   <= adc_req_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef DC_SWEEP_AVG_EN
    // Conversion counter and sum for the 4-sample average.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_cnt_q <= '0;
            avg_acc_q <= '0;
        end else begin
            avg_cnt_q <= avg_cnt_d;
            avg_acc_q <= avg_acc_d;
        end
    end
`endif

    assign vg_code   = vg_code_q;
    assign vd_code   = vd_code_q;
    assign dac_load  = dac_load_q;
    assign adc_req   = adc_req_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_last  = res_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
